vga_timing_gen: RTL and testbench

//  Raster timing source for the VGA path: generates DrawX/DrawY scan position,

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Raster timing generator for a 640x480@60Hz VGA frame on the pixel clock.
// Scan position, blank, line/frame pulses and a delayed hs/vs pair.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 640,
    parameter int H_FRONT    = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BACK     = 48,
    parameter int V_VISIBLE  = 480,
    parameter int V_FRONT    = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BACK     = 33,
    parameter int SYNC_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS_W  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS_W  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_STA_W = 11'(HS_START);
    localparam logic [10:0] HS_END_W = 11'(HS_END);
    localparam logic [10:0] VS_STA_W = 11'(VS_START);
    localparam logic [10:0] VS_END_W = 11'(VS_END);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL < 2 || V_TOTAL < 2) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must lie in 2..1024");
        end
        if (SYNC_DELAY < 0 || SYNC_DELAY > 4) begin : g_bad_delay
            $error("vga_timing_gen: SYNC_DELAY must lie in 0..4");
        end
    endgenerate

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [9:0]  next_hc;
    logic [9:0]  next_vc;
    logic [10:0] next_hc_w;
    logic [10:0] next_vc_w;
    logic        next_blank;
    logic        next_hs_raw;
    logic        next_vs_raw;
    logic        frame_wrap;

    // Stage 0 holds the undelayed decode; stages 1..SYNC_DELAY form the delay line.
    logic [SYNC_DELAY:0] hs_line;
    logic [SYNC_DELAY:0] vs_line;

    always_comb begin
        next_hc = hc + 10'd1;
        next_vc = vc;
        if (hc == H_LAST) begin
            next_hc = '0;
            next_vc = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end
        next_hc_w   = {1'b0, next_hc};
        next_vc_w   = {1'b0, next_vc};
        next_blank  = (next_hc_w < H_VIS_W) && (next_vc_w < V_VIS_W);
        next_hs_raw = !((next_hc_w >= HS_STA_W) && (next_hc_w < HS_END_W));
        next_vs_raw = !((next_vc_w >= VS_STA_W) && (next_vc_w < VS_END_W));
        frame_wrap  = (next_hc == 10'd0) && (next_vc == 10'd0);
    end

    // Decoding from the next counter state keeps every registered output aligned with DrawX/DrawY.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc          <= H_LAST;
            vc          <= V_LAST;
            blank       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= 8'hFF;
            hs_line     <= '1;
            vs_line     <= '1;
        end else begin
            hc          <= next_hc;
            vc          <= next_vc;
            blank       <= next_blank;
            line_start  <= (next_hc == 10'd0);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_count <= frame_count + 8'd1;
            end
            hs_line[0] <= next_hs_raw;
            vs_line[0] <= next_vs_raw;
            for (int i = 1; i <= SYNC_DELAY; i++) begin
                hs_line[i] <= hs_line[i-1];
                vs_line[i] <= vs_line[i-1];
            end
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;
    assign hs    = hs_line[SYNC_DELAY];
    assign vs    = vs_line[SYNC_DELAY];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance plus shrunken-frame
// instances (delays 1, 0, 3) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct {
        int hvis; int hfront; int hsync; int hback;
        int vvis; int vfront; int vsync; int vback;
        int delay;
    } timing_t;

    typedef struct {
        int x; int y;
        bit blank; bit hs; bit vs; bit ls; bit fs;
        int fc;
    } expect_t;

    logic vga_clk = 1'b0;
    logic reset   = 1'b0;

    logic [3:0][9:0] draw_x;
    logic [3:0][9:0] draw_y;
    logic [3:0][7:0] fc_o;
    logic [3:0]      blank_o;
    logic [3:0]      hs_o;
    logic [3:0]      vs_o;
    logic [3:0]      ls_o;
    logic [3:0]      fs_o;

    int  t_cnt = -1;
    int  checks = 0;
    int  errors = 0;
    bit  run_checks = 1'b0;

    always #5 vga_clk = ~vga_clk;

    vga_timing_gen dut_full (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(draw_x[0]), .DrawY(draw_y[0]), .blank(blank_o[0]),
        .hs(hs_o[0]), .vs(vs_o[0]), .line_start(ls_o[0]),
        .frame_start(fs_o[0]), .frame_count(fc_o[0])
    );

    vga_timing_gen #(
        .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(1)
    ) dut_s1 (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(draw_x[1]), .DrawY(draw_y[1]), .blank(blank_o[1]),
        .hs(hs_o[1]), .vs(vs_o[1]), .line_start(ls_o[1]),
        .frame_start(fs_o[1]), .frame_count(fc_o[1])
    );

    vga_timing_gen #(
        .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(0)
    ) dut_s0 (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(draw_x[2]), .DrawY(draw_y[2]), .blank(blank_o[2]),
        .hs(hs_o[2]), .vs(vs_o[2]), .line_start(ls_o[2]),
        .frame_start(fs_o[2]), .frame_count(fc_o[2])
    );

    vga_timing_gen #(
        .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2), .SYNC_DELAY(3)
    ) dut_s3 (
        .vga_clk(vga_clk), .reset(reset),
        .DrawX(draw_x[3]), .DrawY(draw_y[3]), .blank(blank_o[3]),
        .hs(hs_o[3]), .vs(vs_o[3]), .line_start(ls_o[3]),
        .frame_start(fs_o[3]), .frame_count(fc_o[3])
    );

    function automatic timing_t cfg(input int k);
        timing_t p;
        case (k)
            0:       p = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
            1:       p = '{12, 2, 3, 3, 6, 2, 2, 2, 1};
            2:       p = '{12, 2, 3, 3, 6, 2, 2, 2, 0};
            default: p = '{12, 2, 3, 3, 6, 2, 2, 2, 3};
        endcase
        return p;
    endfunction

    // t = clock edges since reset release minus one; negative means held in reset.
    function automatic expect_t predict(input timing_t p, input int t);
        expect_t e;
        int htot, vtot, ts, xs, ys;
        htot = p.hvis + p.hfront + p.hsync + p.hback;
        vtot = p.vvis + p.vfront + p.vsync + p.vback;
        if (t < 0) begin
            e = '{htot - 1, vtot - 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 255};
            return e;
        end
        e.x     = t % htot;
        e.y     = (t / htot) % vtot;
        e.fc    = (t / (htot * vtot)) % 256;
        e.blank = (e.x < p.hvis) && (e.y < p.vvis);
        e.ls    = (e.x == 0);
        e.fs    = (e.x == 0) && (e.y == 0);
        ts = t - p.delay;
        if (ts < 0) begin
            e.hs = 1'b1;
            e.vs = 1'b1;
        end else begin
            xs = ts % htot;
            ys = (ts / htot) % vtot;
            e.hs = !((xs >= p.hvis + p.hfront) && (xs < p.hvis + p.hfront + p.hsync));
            e.vs = !((ys >= p.vvis + p.vfront) && (ys < p.vvis + p.vfront + p.vsync));
        end
        return e;
    endfunction

    task automatic expect_eq(input string name, input int actual, input int required);
        checks++;
        if (actual != required) begin
            errors++;
            $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", name, t_cnt, actual, required);
        end
    endtask

    task automatic check_output(input int k);
        expect_t e;
        string   n;
        e = predict(cfg(k), t_cnt);
        n = $sformatf("inst%0d", k);
        expect_eq({n, ".DrawX"}, int'(draw_x[k]), e.x);
        expect_eq({n, ".DrawY"}, int'(draw_y[k]), e.y);
        expect_eq({n, ".blank"}, int'(blank_o[k]), int'(e.blank));
        expect_eq({n, ".hs"}, int'(hs_o[k]), int'(e.hs));
        expect_eq({n, ".vs"}, int'(vs_o[k]), int'(e.vs));
        expect_eq({n, ".line_start"}, int'(ls_o[k]), int'(e.ls));
        expect_eq({n, ".frame_start"}, int'(fs_o[k]), int'(e.fs));
        expect_eq({n, ".frame_count"}, int'(fc_o[k]), e.fc);
    endtask

    always @(posedge vga_clk or posedge reset) begin
        if (reset) t_cnt <= -1;
        else       t_cnt <= t_cnt + 1;
    end

    always @(negedge vga_clk) begin
        if (run_checks) begin
            for (int k = 0; k < 4; k++) check_output(k);
        end
    end

    task automatic apply_stimulus(input bit level);
        @(negedge vga_clk);
        #2 reset = level;
    endtask

    task automatic pin_model;
        expect_t e;
        timing_t f;
        f = cfg(0);
        e = predict(f, -1);     expect_eq("model.reset_x", e.x, 799);
                                expect_eq("model.reset_y", e.y, 524);
        e = predict(f, 0);      expect_eq("model.t0_blank", int'(e.blank), 1);
                                expect_eq("model.t0_fc", e.fc, 0);
        e = predict(f, 639);    expect_eq("model.x639_blank", int'(e.blank), 1);
        e = predict(f, 640);    expect_eq("model.x640_blank", int'(e.blank), 0);
        e = predict(f, 656);    expect_eq("model.x656_hs", int'(e.hs), 1);
        e = predict(f, 657);    expect_eq("model.x657_hs", int'(e.hs), 0);
        e = predict(f, 752);    expect_eq("model.x752_hs", int'(e.hs), 0);
        e = predict(f, 753);    expect_eq("model.x753_hs", int'(e.hs), 1);
        e = predict(f, 480*800); expect_eq("model.y480_blank", int'(e.blank), 0);
        e = predict(f, 490*800); expect_eq("model.vs_edge0", int'(e.vs), 1);
        e = predict(f, 490*800 + 1); expect_eq("model.vs_edge1", int'(e.vs), 0);
        e = predict(f, 492*800 + 1); expect_eq("model.vs_end", int'(e.vs), 1);
        e = predict(f, 420000); expect_eq("model.frame1_fs", int'(e.fs), 1);
                                expect_eq("model.frame1_fc", e.fc, 1);
    endtask

    initial begin
        int hs_low, hs_first, ls_cnt, period, vs1_low, vs1_x, vs1_y, vs0_x, vs0_y, guard;
        bit found;

        pin_model();
        #1 reset = 1'b1;
        run_checks = 1'b1;
        repeat (3) @(negedge vga_clk);
        apply_stimulus(1'b0);

        // First cycle after release.
        @(negedge vga_clk);
        expect_eq("rel.DrawX", int'(draw_x[0]), 0);
        expect_eq("rel.DrawY", int'(draw_y[0]), 0);
        expect_eq("rel.blank", int'(blank_o[0]), 1);
        expect_eq("rel.frame_start", int'(fs_o[0]), 1);
        expect_eq("rel.frame_count", int'(fc_o[0]), 0);

        // One full line on the 640x480 instance.
        hs_low = 0; hs_first = -1; ls_cnt = 0;
        for (int i = 0; i < 800; i++) begin
            if (!hs_o[0]) begin
                if (hs_first < 0) hs_first = int'(draw_x[0]);
                hs_low++;
            end
            if (ls_o[0]) ls_cnt++;
            @(negedge vga_clk);
        end
        expect_eq("line.hs_low_cycles", hs_low, 96);
        expect_eq("line.hs_first_x", hs_first, 657);
        expect_eq("line.line_start_count", ls_cnt, 1);

        // One full small frame: period and vsync placement for delays 1 and 0.
        guard = 0;
        while (!fs_o[1] && guard < 1000) begin
            @(negedge vga_clk);
            guard++;
        end
        expect_eq("small.fs_seen", int'(fs_o[1]), 1);
        period = 0; vs1_low = 0; vs1_x = -1; vs1_y = -1; vs0_x = -1; vs0_y = -1;
        do begin
            if (!vs_o[1]) begin
                vs1_low++;
                if (vs1_x < 0) begin vs1_x = int'(draw_x[1]); vs1_y = int'(draw_y[1]); end
            end
            if (!vs_o[2] && vs0_x < 0) begin vs0_x = int'(draw_x[2]); vs0_y = int'(draw_y[2]); end
            @(negedge vga_clk);
            period++;
        end while (!fs_o[1] && period < 1000);
        expect_eq("small.frame_period", period, 240);
        expect_eq("small.vs_low_cycles", vs1_low, 40);
        expect_eq("small.d1_vs_fall_x", vs1_x, 1);
        expect_eq("small.d1_vs_fall_y", vs1_y, 8);
        expect_eq("small.d0_vs_fall_x", vs0_x, 0);
        expect_eq("small.d0_vs_fall_y", vs0_y, 8);

        // Reset in the middle of a frame.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge vga_clk);
            found = (draw_x[1] == 10'd5) && (draw_y[1] == 10'd3);
        end
        expect_eq("mid.position_found", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        expect_eq("mid.full_DrawX", int'(draw_x[0]), 799);
        expect_eq("mid.full_DrawY", int'(draw_y[0]), 524);
        expect_eq("mid.full_blank", int'(blank_o[0]), 0);
        expect_eq("mid.full_hs", int'(hs_o[0]), 1);
        expect_eq("mid.full_vs", int'(vs_o[0]), 1);
        expect_eq("mid.small_DrawX", int'(draw_x[1]), 19);
        expect_eq("mid.small_DrawY", int'(draw_y[1]), 11);
        expect_eq("mid.small_fc", int'(fc_o[1]), 255);
        apply_stimulus(1'b0);
        @(negedge vga_clk);
        expect_eq("restart.DrawX", int'(draw_x[0]), 0);
        expect_eq("restart.DrawY", int'(draw_y[0]), 0);
        expect_eq("restart.fc", int'(fc_o[0]), 0);
        expect_eq("restart.small_fc", int'(fc_o[1]), 0);

        // Frame counter wrap on the small frame (240 cycles per frame).
        guard = 0;
        while (t_cnt != 255*240 && guard < 70000) begin
            @(negedge vga_clk);
            guard++;
        end
        expect_eq("wrap.reached_255", t_cnt, 255*240);
        expect_eq("wrap.fc_255", int'(fc_o[1]), 255);
        expect_eq("wrap.fs_255", int'(fs_o[1]), 1);
        repeat (240) @(negedge vga_clk);
        expect_eq("wrap.fc_0_d1", int'(fc_o[1]), 0);
        expect_eq("wrap.fc_0_d0", int'(fc_o[2]), 0);
        expect_eq("wrap.fs_0", int'(fs_o[1]), 1);

        run_checks = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
